// File: rtl/ripple_monitor_pkg.sv
// ripple_monitor_pkg: shared event kinds, tracker states and sizing constants
package ripple_monitor_pkg;
  typedef enum logic [1:0] {STEP = 2'b00, WRAP = 2'b01, ERR = 2'b10, RESYNC = 2'b11} evt_kind_t;
  typedef enum logic {SEED, TRACK} state_t;
  localparam int FIFO_DEPTH = 4;
  localparam int RUN_W = 4;
endpackage

// File: rtl/ripple_stable_filter.sv
// ripple_stable_filter: two-flop synchroniser plus run-length filter that pulses accept once per stable value
module ripple_stable_filter import ripple_monitor_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int STABLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] cand,
  output logic             accept
);
  logic [WIDTH-1:0] s1, s2;
  logic [RUN_W-1:0] run;
  // synchronise, restart the run on any change, saturate so accept fires only once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      run <= '0;
    end else begin
      s1 <= q_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        run <= RUN_W'(1);
      end else if (run != RUN_W'(STABLE)) run <= run + RUN_W'(1);
    end
  end
  assign accept = (s2 == cand) && (run == RUN_W'(STABLE - 1));
endmodule

// File: rtl/ripple_monitor.sv
// ripple_monitor: classifies filtered ripple-counter values into events; RIPPLE_MONITOR_FIFO_EN selects a 4-entry event FIFO
module ripple_monitor import ripple_monitor_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int STABLE = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              clr,
  output logic [WIDTH-1:0]  count_out,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err,
  output logic              ovf,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_kind,
  output logic [WIDTH-1:0]  evt_value
);
  state_t state, state_nx;
  evt_kind_t kind;
  logic [WIDTH-1:0] cand;
  logic accept, evt, push, pop;
  ripple_stable_filter #(.WIDTH(WIDTH), .STABLE(STABLE)) u_filt (
    .clk(clk), .rst(rst), .q_in(q_in), .cand(cand), .accept(accept)
  );
  // next state and classification of a newly accepted value against the last one
  always_comb begin
    state_nx = (state == SEED && accept) ? TRACK : state;
    evt = (state == TRACK) && accept && (cand != count_out);
    kind = (count_out == '0 && cand == '1) ? WRAP :
           (cand == count_out - WIDTH'(1)) ? STEP :
           (cand == '0) ? RESYNC : ERR;
  end
  // tracker state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEED;
    else state <= state_nx;
  end
  // accepted value, wrap counter and sticky flags; events take priority over clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_out <= '0;
      wrap_cnt <= '0;
      step_err <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (accept) count_out <= cand;
      if (evt && kind == WRAP) wrap_cnt <= wrap_cnt + WRAP_W'(~&wrap_cnt);
      else if (clr) wrap_cnt <= '0;
      if (evt && kind == ERR) step_err <= 1'b1;
      else if (clr) step_err <= 1'b0;
      if (evt && !push) ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end
`ifdef RIPPLE_MONITOR_FIFO_EN
  logic [WIDTH+1:0] mem [FIFO_DEPTH];
  logic [1:0] wp, rp;
  logic [2:0] occ;
  assign evt_valid = occ != 3'd0;
  assign pop = evt_valid && evt_ready;
  assign push = evt && (occ != 3'(FIFO_DEPTH) || pop);
  assign {evt_kind, evt_value} = evt_valid ? mem[rp] : '0;
  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {kind, cand};
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      occ <= occ + 3'(push) - 3'(pop);
    end
  end
`else
  logic [WIDTH+1:0] hold_q;
  assign pop = evt_valid && evt_ready;
  assign push = evt && (!evt_valid || evt_ready);
  assign {evt_kind, evt_value} = hold_q;
  // single holding register, stable until the consumer takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      hold_q <= '0;
    end else if (push) begin
      evt_valid <= 1'b1;
      hold_q <= {kind, cand};
    end else if (pop) evt_valid <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_ripple_monitor.sv
// tb_ripple_monitor: directed and randomized checks of ripple_monitor against a value-sequence model
module tb_ripple_monitor;
  localparam logic [1:0] K_STEP = 2'b00, K_WRAP = 2'b01, K_ERR = 2'b10, K_RESYNC = 2'b11;
  logic clk = 0, rst = 0, clr = 0, evt_ready = 1;
  logic [3:0] q_in = 0;
  logic [3:0] count_out, evt_value;
  logic [7:0] wrap_cnt;
  logic step_err, ovf, evt_valid;
  logic [1:0] evt_kind;
  int n_checks = 0, n_fail = 0;
  logic [5:0] obs_q[$], exp_q[$];
  logic seen_valid = 0;

  ripple_monitor dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr), .count_out(count_out),
    .wrap_cnt(wrap_cnt), .step_err(step_err), .ovf(ovf), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_kind(evt_kind), .evt_value(evt_value)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] classify(input logic [3:0] p, input logic [3:0] n);
    if (p == 4'd0 && n == 4'd15) return K_WRAP;
    if (n == 4'(p - 4'd1)) return K_STEP;
    if (n == 4'd0) return K_RESYNC;
    return K_ERR;
  endfunction

  task automatic step();
    if (evt_valid && evt_ready) obs_q.push_back({evt_kind, evt_value});
    seen_valid = seen_valid | evt_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    q_in = v;
    repeat (n) step();
  endtask

  task automatic pulse_clr();
    clr = 1;
    step();
    clr = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({count_out, wrap_cnt, step_err, ovf, evt_valid, evt_kind, evt_value} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {count_out, wrap_cnt, step_err, ovf, evt_valid, evt_kind, evt_value});
    end
    @(posedge clk);
    #1;
    rst = 1;
    hold(0, 6);
    hold(15, 8);
    n_checks++;
    if (count_out !== 4'd15) begin
      n_fail++;
      $display("FAIL pre_async_count: got %0d expected 15", count_out);
    end
    #2 rst = 0;
    #1;
    n_checks++;
    if ({count_out, wrap_cnt, step_err, ovf, evt_valid, evt_kind, evt_value} !== 22'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", {count_out, wrap_cnt, step_err, ovf, evt_valid, evt_kind, evt_value});
    end
    q_in = 0;
    @(posedge clk);
    #1;
    rst = 1;
    seen_valid = 0;
    hold(0, 20);
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_event: got evt_valid %b expected 0", seen_valid);
    end
    n_checks++;
    if (count_out !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", count_out);
    end
    obs_q.delete();
  endtask

  task automatic test_wrap_step();
    obs_q.delete();
    q_in = 15;
    repeat (3) step();
    n_checks++;
    if (evt_valid !== 1'b0 || count_out !== 4'd0) begin
      n_fail++;
      $display("FAIL latency_early: got valid %b count %0d expected 0 0", evt_valid, count_out);
    end
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || count_out !== 4'd15) begin
      n_fail++;
      $display("FAIL latency_edge4: got valid %b count %0d expected 1 15", evt_valid, count_out);
    end
    hold(15, 6);
    hold(14, 10);
    hold(13, 10);
    exp_q = '{{K_WRAP, 4'd15}, {K_STEP, 4'd14}, {K_STEP, 4'd13}};
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_step_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_step_evt[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 6'h3f, exp_q[i]);
      end
    end
    n_checks++;
    if (wrap_cnt !== 8'd1 || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_step_regs: got wrap %0d err %b expected 1 0", wrap_cnt, step_err);
    end
  endtask

  task automatic test_glitch();
    obs_q.delete();
    hold(12, 5);
    hold(7, 1);
    hold(12, 5);
    hold(6, 1);
    hold(12, 6);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {K_STEP, 4'd12} || count_out !== 4'd12) begin
      n_fail++;
      $display("FAIL glitch: got %0d events first %h count %0d expected 1 event %h count 12", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 6'h3f, count_out, {K_STEP, 4'd12});
    end
  endtask

  task automatic test_err_clr();
    obs_q.delete();
    hold(9, 10);
    hold(4, 10);
    exp_q = '{{K_ERR, 4'd9}, {K_ERR, 4'd4}};
    n_checks++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      n_fail++;
      $display("FAIL err_events: got %0d events expected ERR9 ERR4", obs_q.size());
    end
    n_checks++;
    if (step_err !== 1'b1 || count_out !== 4'd4) begin
      n_fail++;
      $display("FAIL err_regs: got err %b count %0d expected 1 4", step_err, count_out);
    end
    pulse_clr();
    n_checks++;
    if (step_err !== 1'b0 || wrap_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clr: got err %b wrap %0d expected 0 0", step_err, wrap_cnt);
    end
  endtask

  task automatic test_resync();
    hold(6, 10);
    pulse_clr();
    obs_q.delete();
    hold(0, 10);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {K_RESYNC, 4'd0} || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL resync: got %0d events first %h err %b expected 1 event %h err 0", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 6'h3f, step_err, {K_RESYNC, 4'd0});
    end
  endtask

  task automatic test_backpressure();
    hold(3, 10);
    pulse_clr();
    obs_q.delete();
    evt_ready = 0;
    hold(2, 10);
    n_checks++;
    if (evt_valid !== 1'b1 || {evt_kind, evt_value} !== {K_STEP, 4'd2}) begin
      n_fail++;
      $display("FAIL bp_first: got valid %b evt %h expected 1 %h", evt_valid, {evt_kind, evt_value}, {K_STEP, 4'd2});
    end
    hold(1, 10);
    n_checks++;
    if (evt_valid !== 1'b1 || {evt_kind, evt_value} !== {K_STEP, 4'd2} || count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL bp_held: got valid %b evt %h count %0d expected 1 %h 1", evt_valid, {evt_kind, evt_value}, count_out, {K_STEP, 4'd2});
    end
`ifdef RIPPLE_MONITOR_FIFO_EN
    exp_q = '{{K_STEP, 4'd2}, {K_STEP, 4'd1}};
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ovf: got %b expected 0", ovf);
    end
`else
    exp_q = '{{K_STEP, 4'd2}};
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ovf: got %b expected 1", ovf);
    end
`endif
    evt_ready = 1;
    repeat (3) step();
    n_checks++;
    if (obs_q.size() != exp_q.size() || obs_q[0] !== exp_q[0] || obs_q[obs_q.size()-1] !== exp_q[exp_q.size()-1] || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d events valid %b expected %0d events valid 0", obs_q.size(), evt_valid, exp_q.size());
    end
    pulse_clr();
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got %b expected 0", ovf);
    end
  endtask

  task automatic test_wrap_sat();
    hold(0, 8);
    pulse_clr();
    for (int i = 0; i < 260; i++) begin
      hold(15, 6);
      hold(0, 6);
    end
    n_checks++;
    if (wrap_cnt !== 8'd255 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_sat: got wrap %0d ovf %b expected 255 0", wrap_cnt, ovf);
    end
    pulse_clr();
    n_checks++;
    if (wrap_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_clr: got %0d expected 0", wrap_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] m_count, v, g;
    logic [7:0] m_wrap;
    logic m_err;
    logic [1:0] k;
    int n, pos;
    m_count = 0;
    m_wrap = 0;
    m_err = 0;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      v = ($urandom % 2 == 0) ? 4'(m_count - 4'd1) : 4'($urandom_range(0, 15));
      n = $urandom_range(6, 12);
      if (v != m_count) begin
        k = classify(m_count, v);
        exp_q.push_back({k, v});
        if (k == K_WRAP && m_wrap != 8'hff) m_wrap++;
        if (k == K_ERR) m_err = 1;
        m_count = v;
      end
      if ($urandom % 3 == 0) begin
        pos = $urandom_range(1, n - 2);
        g = v ^ 4'($urandom_range(1, 15));
        hold(v, pos);
        hold(g, 1);
        hold(v, n - pos - 1);
      end else hold(v, n);
    end
    hold(m_count, 8);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_evt[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 6'h3f, exp_q[i]);
      end
    end
    n_checks++;
    if (count_out !== m_count || wrap_cnt !== m_wrap || step_err !== m_err || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_regs: got count %0d wrap %0d err %b ovf %b expected %0d %0d %b 0", count_out, wrap_cnt, step_err, ovf, m_count, m_wrap, m_err);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_step();
    test_glitch();
    test_err_clr();
    test_resync();
    test_backpressure();
    test_wrap_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
